// File: rtl/core_run_ctrl_pkg.sv
// Shared types and default sizing for the run-control sequencer.
// Optional feature macro used by the top: BREAKPOINT_EN.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_HALT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_STEP    = 3'd3,
        ST_TRAPPED = 3'd4
    } state_e;

    localparam int DEF_DIV_W      = 23;
    localparam int DEF_DEB_CYCLES = 65536;
    localparam int DEF_RST_CYCLES = 16;
    localparam int DEF_LED_W      = 11;

endpackage

// File: rtl/core_run_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one board switch.
// The output only follows the synced input after DEB_CYCLES consecutive differing cycles.
module sw_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic resetn,
    input  logic sw_i,
    output logic deb_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        // Any cycle where the synced input agrees with the output restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: core clock-enable, run/step/trap handling, core reset sequencing.
// Define BREAKPOINT_EN to add the bp_addr/bp_valid breakpoint inputs.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int LED_W      = DEF_LED_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sw_run,
    input  logic             sw_step,
    input  logic             trap,
    input  logic [31:0]      pc,
`ifdef BREAKPOINT_EN
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
`endif
    output logic             core_ce,
    output logic             core_resetn,
    output logic             halted,
    output logic             trapped,
    output logic [LED_W-1:0] led_pc,
    output logic [31:0]      ce_count,
    output state_e           dbg_state
);

    localparam int RCW = $clog2(RST_CYCLES + 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [RCW-1:0]   rst_cnt_q;
    logic             run_deb, step_deb;
    logic             run_prev_q, step_prev_q;
    logic             ce_prev_q;
    logic             core_resetn_q, halted_q, trapped_q;
    logic [LED_W-1:0] led_q;
    logic [31:0]      ce_count_q;
    logic             tick, step_edge, run_fall, bp_hit;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .resetn(resetn), .sw_i(sw_run), .deb_o(run_deb)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .resetn(resetn), .sw_i(sw_step), .deb_o(step_deb)
    );

    assign tick      = &div_q;
    assign step_edge = step_deb & ~step_prev_q;
    assign run_fall  = run_prev_q & ~run_deb;
    assign core_ce   = tick & ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~trap;

`ifdef BREAKPOINT_EN
    // pc already reflects the step taken by the previous enable pulse.
    assign bp_hit = ce_prev_q & bp_valid & (pc == bp_addr);
`else
    assign bp_hit = 1'b0;
    if (LED_W < 32) begin : g_unused_pc
        logic unused_pc;
        assign unused_pc = ^pc[31:LED_W];
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = run_deb ? ST_RUN : ST_HALT;
            ST_HALT:    if (run_deb) state_d = ST_RUN;
                        else if (step_edge) state_d = ST_STEP;
            ST_RUN:     if (trap) state_d = ST_TRAPPED;
                        else if (!run_deb || bp_hit) state_d = ST_HALT;
            ST_STEP:    if (trap) state_d = ST_TRAPPED;
                        else if (tick) state_d = ST_HALT;
            ST_TRAPPED: if (run_fall) state_d = ST_RESET;
            default:    state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_RESET;
            div_q         <= '0;
            rst_cnt_q     <= '0;
            run_prev_q    <= 1'b0;
            step_prev_q   <= 1'b0;
            ce_prev_q     <= 1'b0;
            core_resetn_q <= 1'b0;
            halted_q      <= 1'b0;
            trapped_q     <= 1'b0;
            led_q         <= '0;
            ce_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_q + 1'b1;
            rst_cnt_q     <= (state_q == ST_RESET) ? rst_cnt_q + 1'b1 : '0;
            run_prev_q    <= run_deb;
            step_prev_q   <= step_deb;
            ce_prev_q     <= core_ce;
            core_resetn_q <= (state_d != ST_RESET);
            halted_q      <= (state_d == ST_HALT) || (state_d == ST_TRAPPED);
            trapped_q     <= (state_d == ST_TRAPPED);
            if (ce_prev_q || (state_d == ST_TRAPPED && state_q != ST_TRAPPED)) begin
                led_q <= pc[LED_W-1:0];
            end
            if (state_d == ST_RESET && state_q != ST_RESET) begin
                ce_count_q <= '0;
            end else if (core_ce) begin
                ce_count_q <= ce_count_q + 32'd1;
            end
        end
    end

    assign core_resetn = core_resetn_q;
    assign halted      = halted_q;
    assign trapped     = trapped_q;
    assign led_pc      = led_q;
    assign ce_count    = ce_count_q;
    assign dbg_state   = state_q;

endmodule
